mem_bus_master: RTL

- Initiator for the shared `mem` tri-state bus (`sel`, `w_en`, `address_bus`, `data_bus`); it is the other end of that interface.
- Accepts burst read/write commands from accelerator datapath logic over valid/ready, sequences them onto the memory bus, and returns read data.
- Handles the memory's 1-cycle registered read latency by pipelining addresses.
- Sits between CNN compute engines and one `mem` instance.

---
 rtl/mem_bus_pkg.sv | 17 +
 rtl/mem_bus_master_if.sv | 32 +++
 rtl/mem_bus_tristate.sv | 20 ++
 rtl/mem_bus_master.sv | 132 +++++++++++++
 4 files changed

// File: rtl/mem_bus_pkg.sv
// Shared definitions for the mem bus: FSM states and default bus geometry.
package mem_bus_pkg;

    localparam int unsigned MEM_DATA_WIDTH    = 32;
    localparam int unsigned MEM_ADDRESS_WIDTH = 8;
    localparam int unsigned MEM_LEN_WIDTH     = 8;

    // TURN is only entered when MEM_BUS_TURNAROUND_EN is defined.
    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        WRITE     = 3'd1,
        READ      = 3'd2,
        READ_LAST = 3'd3,
        TURN      = 3'd4
    } mem_bus_state_e;

endpackage

// File: rtl/mem_bus_master_if.sv
// Command / write-beat / read-beat handshakes between datapath logic and mem_bus_master.
interface mem_bus_master_if
    import mem_bus_pkg::*;
#(
    parameter int unsigned DATA_WIDTH    = MEM_DATA_WIDTH,
    parameter int unsigned ADDRESS_WIDTH = MEM_ADDRESS_WIDTH,
    parameter int unsigned LEN_WIDTH     = MEM_LEN_WIDTH
);
    logic                     cmd_valid;
    logic                     cmd_ready;
    logic                     cmd_we;
    logic [ADDRESS_WIDTH-1:0] cmd_addr;
    logic [LEN_WIDTH-1:0]     cmd_len;
    logic                     wr_valid;
    logic                     wr_ready;
    logic [DATA_WIDTH-1:0]    wr_data;
    logic                     rd_valid;
    logic [DATA_WIDTH-1:0]    rd_data;
    logic                     busy;

    // Datapath side: issues commands and write beats, consumes read beats.
    modport master (
        output cmd_valid, cmd_we, cmd_addr, cmd_len, wr_valid, wr_data,
        input  cmd_ready, wr_ready, rd_valid, rd_data, busy
    );

    // Bus master side.
    modport slave (
        input  cmd_valid, cmd_we, cmd_addr, cmd_len, wr_valid, wr_data,
        output cmd_ready, wr_ready, rd_valid, rd_data, busy
    );
endinterface

// File: rtl/mem_bus_tristate.sv
// Output enables and Z release for the shared address/data bus.
module mem_bus_tristate
    import mem_bus_pkg::*;
#(
    parameter int unsigned DATA_WIDTH    = MEM_DATA_WIDTH,
    parameter int unsigned ADDRESS_WIDTH = MEM_ADDRESS_WIDTH
) (
    input  logic                     oe_addr,
    input  logic                     oe_data,
    input  logic [ADDRESS_WIDTH-1:0] addr_out,
    input  logic [DATA_WIDTH-1:0]    data_out,
    inout  wire  [ADDRESS_WIDTH-1:0] address_bus,
    inout  wire  [DATA_WIDTH-1:0]    data_bus
);

    // Drive only while enabled; otherwise leave the bus to the memory.
    assign address_bus = oe_addr ? addr_out : {ADDRESS_WIDTH{1'bz}};
    assign data_bus    = oe_data ? data_out : {DATA_WIDTH{1'bz}};

endmodule

// File: rtl/mem_bus_master.sv
// Burst initiator for the shared mem tri-state bus.
// Optional: define MEM_BUS_TURNAROUND_EN to insert a one-cycle TURN state
// between a read burst and a following write burst.
module mem_bus_master
    import mem_bus_pkg::*;
#(
    parameter int unsigned DATA_WIDTH    = MEM_DATA_WIDTH,
    parameter int unsigned ADDRESS_WIDTH = MEM_ADDRESS_WIDTH,
    parameter int unsigned LEN_WIDTH     = MEM_LEN_WIDTH
) (
    input  logic                     clk,
    input  logic                     rst,
    mem_bus_master_if.slave          bus,
    output logic                     mem_sel,
    output logic                     mem_w_en,
    inout  wire  [ADDRESS_WIDTH-1:0] address_bus,
    inout  wire  [DATA_WIDTH-1:0]    data_bus
);

    mem_bus_state_e           state;
    logic [ADDRESS_WIDTH-1:0] addr;
    logic [LEN_WIDTH-1:0]     cnt;
    logic                     rd_first;
    logic                     rd_valid_q;
    logic [DATA_WIDTH-1:0]    rd_data_q;
    logic                     accept;
    logic                     capture;
`ifdef MEM_BUS_TURNAROUND_EN
    logic                     last_was_read;
`endif

    // Handshake and bus-control decode from the current state.
    assign accept        = bus.cmd_valid && bus.cmd_ready;
    assign bus.cmd_ready = (state == IDLE) && !rst;
    assign bus.busy      = (state != IDLE);
    assign bus.wr_ready  = (state == WRITE) && bus.wr_valid;
    assign bus.rd_valid  = rd_valid_q;
    assign bus.rd_data   = rd_data_q;
    assign mem_sel       = ((state == WRITE) && bus.wr_valid) ||
                           (state == READ) || (state == READ_LAST);
    assign mem_w_en      = (state == WRITE);

    // Memory answers one cycle after the address, so the first READ cycle has nothing to capture.
    assign capture = ((state == READ) && !rd_first) || (state == READ_LAST);

    // Burst sequencer and read-data capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            addr       <= '0;
            cnt        <= '0;
            rd_first   <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
`ifdef MEM_BUS_TURNAROUND_EN
            last_was_read <= 1'b0;
`endif
        end else begin
            rd_valid_q <= capture;
            if (capture) begin
                rd_data_q <= data_bus;
            end

            case (state)
                IDLE: begin
                    if (accept) begin
                        addr     <= bus.cmd_addr;
                        cnt      <= bus.cmd_len;
                        rd_first <= !bus.cmd_we;
                        if (!bus.cmd_we) begin
                            state <= READ;
                        end else begin
`ifdef MEM_BUS_TURNAROUND_EN
                            state <= last_was_read ? TURN : WRITE;
`else
                            state <= WRITE;
`endif
                        end
                    end
                end
                WRITE: begin
                    if (bus.wr_valid) begin
                        addr <= addr + ADDRESS_WIDTH'(1);
                        cnt  <= cnt - LEN_WIDTH'(1);
                        if (cnt == '0) begin
                            state <= IDLE;
`ifdef MEM_BUS_TURNAROUND_EN
                            last_was_read <= 1'b0;
`endif
                        end
                    end
                end
                READ: begin
                    rd_first <= 1'b0;
                    if (cnt == '0) begin
                        // Hold the final address through READ_LAST.
                        state <= READ_LAST;
                    end else begin
                        addr <= addr + ADDRESS_WIDTH'(1);
                        cnt  <= cnt - LEN_WIDTH'(1);
                    end
                end
                READ_LAST: begin
                    state <= IDLE;
`ifdef MEM_BUS_TURNAROUND_EN
                    last_was_read <= 1'b1;
`endif
                end
`ifdef MEM_BUS_TURNAROUND_EN
                TURN: begin
                    state         <= WRITE;
                    last_was_read <= 1'b0;
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end

    mem_bus_tristate #(
        .DATA_WIDTH    (DATA_WIDTH),
        .ADDRESS_WIDTH (ADDRESS_WIDTH)
    ) u_tristate (
        .oe_addr     (mem_sel),
        .oe_data     (mem_sel && mem_w_en),
        .addr_out    (addr),
        .data_out    (bus.wr_data),
        .address_bus (address_bus),
        .data_bus    (data_bus)
    );

endmodule
